// File: rtl/xip_pkg.sv
// Shared definitions for the XIP flash arbiter and the flash controller:
// controller op codes, arbiter state encoding and read-buffer tag width.
package xip_pkg;

    // Op codes as seen on the controller port.
    typedef enum logic [1:0] {
        OP_READ         = 2'd0,
        OP_WRITE        = 2'd1,
        OP_SECTOR_ERASE = 2'd2,
        OP_QUAD_ENABLE  = 2'd3
    } xip_op_e;

    // Arbiter states.
    typedef enum logic [1:0] {
        S_BOOT      = 2'd0,
        S_BOOT_WAIT = 2'd1,
        S_IDLE      = 2'd2,
        S_WAIT      = 2'd3
    } arb_state_e;

    // Read buffer tags on word address bits [23:2].
    localparam int unsigned RDBUF_TAG_W = 22;

    // The controller only ever sees word-aligned addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/xip_rd_buf.sv
// One-entry read buffer: remembers the word tag and data of the last
// completed controller READ so a repeat read can be served locally.
module xip_rd_buf
    import xip_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   fill_i,
    input  logic [RDBUF_TAG_W-1:0] fill_tag_i,
    input  logic [31:0]            fill_data_i,
    input  logic                   clr_i,
    input  logic [RDBUF_TAG_W-1:0] lookup_tag_i,
    output logic                   hit_o,
    output logic [31:0]            data_o
);

    logic                   valid_q;
    logic [RDBUF_TAG_W-1:0] tag_q;
    logic [31:0]            data_q;

    // Entry storage; a clear takes precedence over a fill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
        end
    end

    assign hit_o  = valid_q & (tag_q == lookup_tag_i);
    assign data_o = data_q;

endmodule

// File: rtl/xip_flash_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one flash
// controller. Data port has priority; a starvation counter forces an ifetch
// grant after STARVE_LIMIT consecutive data grants. Optionally issues a
// quad-enable after reset (BOOT_QE).
// Optional feature: define XIP_ARB_RDBUF_EN to add a one-entry read buffer.
module xip_flash_arbiter
    import xip_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          BOOT_QE      = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ifetch_req_i,
    input  logic [31:0] ifetch_addr_i,
    output logic        ifetch_gnt_o,
    output logic        ifetch_rvalid_o,
    output logic [31:0] ifetch_rdata_o,
    input  logic        data_req_i,
    input  logic [1:0]  data_op_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        ctrl_req_o,
    output logic [1:0]  ctrl_op_o,
    output logic [31:0] ctrl_addr_o,
    output logic [31:0] ctrl_wdata_o,
    input  logic        ctrl_valid_i,
    input  logic [31:0] ctrl_rdata_i,
    output logic        init_done_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic             boot_go_q;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             init_done_q;
    logic             owner_data_q, owner_data_d;
    logic             if_rvalid_q, if_rvalid_d;
    logic             dt_rvalid_q, dt_rvalid_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      dt_rdata_q, dt_rdata_d;

    logic             any_req;
    logic             pick_if;
    xip_op_e          win_op;
    logic [31:0]      win_addr;
    logic [31:0]      win_wdata;
    logic             buf_hit;
    logic [31:0]      buf_data;

    // Address LSBs never reach the controller.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{ifetch_addr_i[1:0], data_addr_i[1:0]};

    // Winner selection: data first unless ifetch has been starved long enough.
    assign any_req   = ifetch_req_i | data_req_i;
    assign pick_if   = ifetch_req_i & (~data_req_i | (starve_q == STARVE_MAX));
    assign win_op    = pick_if ? OP_READ : xip_op_e'(data_op_i);
    assign win_addr  = pick_if ? word_align(ifetch_addr_i) : word_align(data_addr_i);
    assign win_wdata = pick_if ? 32'h0 : data_wdata_i;

`ifdef XIP_ARB_RDBUF_EN
    logic                   win_read;
    logic                   grant_cycle;
    logic                   rb_hit, rb_fill, rb_clr;
    logic                   owner_read_q;
    logic [RDBUF_TAG_W-1:0] owner_tag_q;

    assign grant_cycle = (state_q == S_IDLE) & any_req;
    assign win_read    = pick_if | (data_op_i == OP_READ);
    assign buf_hit     = rb_hit & win_read;
    assign rb_clr      = grant_cycle & ~win_read;
    assign rb_fill     = (state_q == S_WAIT) & ctrl_valid_i & owner_read_q;

    // Remember what the controller is working on so its completion can fill the buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_read_q <= 1'b0;
            owner_tag_q  <= '0;
        end else if (grant_cycle && !buf_hit) begin
            owner_read_q <= win_read;
            owner_tag_q  <= win_addr[23:2];
        end
    end

    xip_rd_buf u_rd_buf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fill_i       (rb_fill),
        .fill_tag_i   (owner_tag_q),
        .fill_data_i  (ctrl_rdata_i),
        .clr_i        (rb_clr),
        .lookup_tag_i (win_addr[23:2]),
        .hit_o        (rb_hit),
        .data_o       (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // Next-state, grants, controller request and completion routing.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        owner_data_d = owner_data_q;
        if_rvalid_d  = 1'b0;
        dt_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        dt_rdata_d   = dt_rdata_q;
        ifetch_gnt_o = 1'b0;
        data_gnt_o   = 1'b0;
        ctrl_req_o   = 1'b0;
        ctrl_op_o    = 2'b00;
        ctrl_addr_o  = 32'h0;
        ctrl_wdata_o = 32'h0;

        if (!ifetch_req_i) begin
            starve_d = '0;
        end

        unique case (state_q)
            S_BOOT: begin
                // boot_go_q holds off the boot request while reset is asserted
                if (boot_go_q) begin
                    if (BOOT_QE) begin
                        ctrl_req_o = 1'b1;
                        ctrl_op_o  = OP_QUAD_ENABLE;
                        state_d    = S_BOOT_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BOOT_WAIT: begin
                if (ctrl_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (any_req) begin
                    ifetch_gnt_o = pick_if;
                    data_gnt_o   = ~pick_if;
                    owner_data_d = ~pick_if;
                    if (pick_if) begin
                        starve_d = '0;
                    end else if (ifetch_req_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                    if (buf_hit) begin
                        // Served from the buffer: completion next cycle, stay idle
                        if_rvalid_d = pick_if;
                        dt_rvalid_d = ~pick_if;
                        if (pick_if) begin
                            if_rdata_d = buf_data;
                        end else begin
                            dt_rdata_d = buf_data;
                        end
                    end else begin
                        ctrl_req_o   = 1'b1;
                        ctrl_op_o    = win_op;
                        ctrl_addr_o  = win_addr;
                        ctrl_wdata_o = win_wdata;
                        state_d      = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ctrl_valid_i) begin
                    state_d = S_IDLE;
                    if (owner_data_q) begin
                        dt_rvalid_d = 1'b1;
                        dt_rdata_d  = ctrl_rdata_i;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = ctrl_rdata_i;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_BOOT;
            boot_go_q    <= 1'b0;
            starve_q     <= '0;
            init_done_q  <= 1'b0;
            owner_data_q <= 1'b0;
            if_rvalid_q  <= 1'b0;
            dt_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'h0;
            dt_rdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            boot_go_q    <= 1'b1;
            starve_q     <= starve_d;
            init_done_q  <= init_done_q | (state_d == S_IDLE);
            owner_data_q <= owner_data_d;
            if_rvalid_q  <= if_rvalid_d;
            dt_rvalid_q  <= dt_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dt_rdata_q   <= dt_rdata_d;
        end
    end

    assign ifetch_rvalid_o = if_rvalid_q;
    assign ifetch_rdata_o  = if_rdata_q;
    assign data_rvalid_o   = dt_rvalid_q;
    assign data_rdata_o    = dt_rdata_q;
    assign init_done_o     = init_done_q;
    // Qualified by boot_go_q so busy reads 0 while reset is held.
    assign busy_o          = boot_go_q & (state_q != S_IDLE);

endmodule

// File: tb/tb_xip_flash_arbiter.sv
// Directed bench for xip_flash_arbiter with a latency-programmable
// controller model and a scoreboard of expected completions.
module tb_xip_flash_arbiter;
  import xip_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ifetch_req_i = 1'b0;
  logic [31:0] ifetch_addr_i = 32'h0;
  logic        ifetch_gnt_o, ifetch_rvalid_o;
  logic [31:0] ifetch_rdata_o;
  logic        data_req_i = 1'b0;
  logic [1:0]  data_op_i = 2'd0;
  logic [31:0] data_addr_i = 32'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        ctrl_req_o;
  logic [1:0]  ctrl_op_o;
  logic [31:0] ctrl_addr_o, ctrl_wdata_o;
  logic        ctrl_valid_i;
  logic [31:0] ctrl_rdata_i;
  logic        init_done_o, busy_o;

  always #5 clk_i = ~clk_i;

  xip_flash_arbiter #(.STARVE_LIMIT(4), .BOOT_QE(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ifetch_req_i(ifetch_req_i), .ifetch_addr_i(ifetch_addr_i),
    .ifetch_gnt_o(ifetch_gnt_o), .ifetch_rvalid_o(ifetch_rvalid_o),
    .ifetch_rdata_o(ifetch_rdata_o),
    .data_req_i(data_req_i), .data_op_i(data_op_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .ctrl_req_o(ctrl_req_o), .ctrl_op_o(ctrl_op_o), .ctrl_addr_o(ctrl_addr_o),
    .ctrl_wdata_o(ctrl_wdata_o), .ctrl_valid_i(ctrl_valid_i),
    .ctrl_rdata_i(ctrl_rdata_i),
    .init_done_o(init_done_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C00_0000;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Controller model: accepts a request seen before the edge, answers lat edges later.
  int unsigned lat = 20;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_data = 32'h0;
  initial begin
    ctrl_valid_i = 1'b0;
    ctrl_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      ctrl_valid_i = 1'b0;
      if (!rst_ni) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          ctrl_valid_i = 1'b1;
          ctrl_rdata_i = m_data;
          m_busy = 1'b0;
        end else begin
          m_cnt--;
        end
      end else if (ctrl_req_o) begin
        m_busy = 1'b1;
        m_cnt  = int'(lat);
        m_data = mdata(ctrl_addr_o);
      end
    end
  end

  typedef struct {
    logic        is_data;
    logic [31:0] data;
    logic        dc;
    int          gcyc;
  } exp_t;
  exp_t exp_q[$];

  int          cyc_no = 0, rv_cnt = 0, gnt_cnt = 0, if_gnts = 0, dt_gnts = 0;
  int          boot_reqs = 0, boot_cyc = 0, done_cyc = 0;
  int          last_lat = 0, dt_rv_cyc = 0, if_gnt_cyc = 0, last_gnt_cyc = 0;
  logic        last_gnt_data = 1'b0, last_creq = 1'b0, data_hold = 1'b0;
  logic [1:0]  boot_op = 2'd0, last_cop = 2'd0;
  logic [31:0] last_caddr = 32'h0, last_cwdata = 32'h0;

  // One clock: observe at negedge, then drop granted requests after the edge.
  task automatic cycle();
    exp_t e;
    logic g_if, g_dt;
    logic [31:0] rd;
    @(negedge clk_i);
    cyc_no++;
    if (init_done_o && done_cyc == 0) done_cyc = cyc_no;
    if (ifetch_rvalid_o || data_rvalid_o) begin
      rv_cnt++;
      chk("rvalid_onehot", (ifetch_rvalid_o & data_rvalid_o) === 1'b0,
          ifetch_rvalid_o & data_rvalid_o, 1'b0);
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", exp_q.size() === 1, exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_port", data_rvalid_o === e.is_data, data_rvalid_o, e.is_data);
        rd = e.is_data ? data_rdata_o : ifetch_rdata_o;
        if (!e.dc) chk("rdata", rd === e.data, rd, e.data);
        last_lat = cyc_no - e.gcyc;
        if (e.is_data) dt_rv_cyc = cyc_no;
      end
    end
    g_if = ifetch_gnt_o;
    g_dt = data_gnt_o;
    if (g_if || g_dt) begin
      chk("gnt_onehot", (g_if & g_dt) === 1'b0, g_if & g_dt, 1'b0);
      chk("gnt_after_boot", init_done_o === 1'b1, init_done_o, 1'b1);
      e.is_data = g_dt;
      e.gcyc    = cyc_no;
      e.data    = g_dt ? mdata(align(data_addr_i)) : mdata(align(ifetch_addr_i));
      e.dc      = g_dt && (data_op_i != 2'd0);
      exp_q.push_back(e);
      gnt_cnt++;
      last_gnt_data = g_dt;
      last_gnt_cyc  = cyc_no;
      last_creq     = ctrl_req_o;
      last_caddr    = ctrl_addr_o;
      last_cop      = ctrl_op_o;
      last_cwdata   = ctrl_wdata_o;
      if (g_if) begin
        if_gnts++;
        if_gnt_cyc = cyc_no;
      end else begin
        dt_gnts++;
      end
    end else if (ctrl_req_o) begin
      boot_reqs++;
      boot_op  = ctrl_op_o;
      boot_cyc = cyc_no;
    end
    @(posedge clk_i);
    #1;
    if (g_if) ifetch_req_i = 1'b0;
    if (g_dt && !data_hold) data_req_i = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || ifetch_req_i || data_req_i); i++)
      cycle();
    chk("drain_empty", exp_q.size() === 0, exp_q.size(), 0);
  endtask

  task automatic data_op(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
    data_req_i   = 1'b1;
    data_op_i    = op;
    data_addr_i  = addr;
    data_wdata_i = wd;
  endtask

  int n0, rv0;
  logic [6:0] bits;

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    bits = {ctrl_req_o, ifetch_gnt_o, data_gnt_o, ifetch_rvalid_o, data_rvalid_o,
            init_done_o, busy_o};
    chk("rst_ctrl_bits", bits === 7'b0, bits, 7'b0);
    chk("rst_ctrl_op", ctrl_op_o === 2'd0, ctrl_op_o, 2'd0);
    chk("rst_ctrl_addr", ctrl_addr_o === 32'h0, ctrl_addr_o, 32'h0);
    chk("rst_if_rdata", ifetch_rdata_o === 32'h0, ifetch_rdata_o, 32'h0);
    chk("rst_dt_rdata", data_rdata_o === 32'h0, data_rdata_o, 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Boot QE, with a data read held throughout boot
    data_op(2'd0, 32'h300, 32'h0);
    for (int i = 0; i < 80 && done_cyc == 0; i++) begin
      cycle();
      if (i == 5) lat = 3;
    end
    chk("boot_req_count", boot_reqs === 1, boot_reqs, 1);
    chk("boot_op_qe", boot_op === 2'd3, boot_op, 2'd3);
    chk("boot_done_delay", (done_cyc - boot_cyc) === 21, done_cyc - boot_cyc, 21);
    chk("boot_held_req_granted", gnt_cnt === 1, gnt_cnt, 1);
    chk("boot_held_gnt_port", last_gnt_data === 1'b1, last_gnt_data, 1'b1);
    chk("boot_held_addr", last_caddr === 32'h300, last_caddr, 32'h300);
    drain(20);
    chk("read_latency", last_lat === 4, last_lat, 4);

    // Simultaneous requests: data first, ifetch after data completes
    ifetch_req_i = 1'b1;
    ifetch_addr_i = 32'h100;
    data_op(2'd0, 32'h200, 32'h0);
    cycle();
    chk("both_gnt_data", last_gnt_data === 1'b1, last_gnt_data, 1'b1);
    chk("both_ctrl_addr", last_caddr === 32'h200, last_caddr, 32'h200);
    chk("both_ctrl_req", last_creq === 1'b1, last_creq, 1'b1);
    n0 = if_gnts;
    for (int i = 0; i < 20 && if_gnts == n0; i++) cycle();
    chk("both_if_granted", if_gnts === (n0 + 1), if_gnts, n0 + 1);
    chk("both_if_after_rv",
        ((if_gnt_cyc >= dt_rv_cyc) && (dt_rv_cyc > last_gnt_cyc - 10)) === 1'b1,
        (if_gnt_cyc >= dt_rv_cyc) && (dt_rv_cyc > last_gnt_cyc - 10), 1'b1);
    chk("both_if_addr", last_caddr === 32'h100, last_caddr, 32'h100);
    chk("both_if_op", last_cop === 2'd0, last_cop, 2'd0);
    drain(20);

    // Address alignment
    ifetch_req_i = 1'b1;
    ifetch_addr_i = 32'h2003;
    cycle();
    chk("align_addr", last_caddr === 32'h2000, last_caddr, 32'h2000);
    drain(20);
    chk("align_rdata_held", ifetch_rdata_o === mdata(32'h2000), ifetch_rdata_o,
        mdata(32'h2000));

    // Starvation: continuous data, ifetch pending
    ifetch_req_i = 1'b1;
    ifetch_addr_i = 32'h4000;
    data_hold = 1'b1;
    data_op(2'd0, 32'h5000, 32'h0);
    n0 = dt_gnts;
    rv0 = if_gnts;
    for (int i = 0; i < 100 && if_gnts == rv0; i++) cycle();
    chk("starve_data_gnts", (dt_gnts - n0) === 4, dt_gnts - n0, 4);
    chk("starve_if_addr", last_caddr === 32'h4000, last_caddr, 32'h4000);
    data_hold = 1'b0;
    drain(40);

    // Write / erase / quad-enable complete with rvalid; ifetch rdata held
    rv0 = rv_cnt;
    data_op(2'd1, 32'h1004, 32'hCAFE_F00D);
    cycle();
    chk("wr_op", last_cop === 2'd1, last_cop, 2'd1);
    chk("wr_wdata", last_cwdata === 32'hCAFE_F00D, last_cwdata, 32'hCAFE_F00D);
    drain(20);
    data_op(2'd2, 32'h8000, 32'h0);
    cycle();
    chk("erase_op", last_cop === 2'd2, last_cop, 2'd2);
    drain(20);
    data_op(2'd3, 32'h0, 32'h0);
    cycle();
    chk("qe_op", last_cop === 2'd3, last_cop, 2'd3);
    drain(20);
    chk("nonread_rvalids", (rv_cnt - rv0) === 3, rv_cnt - rv0, 3);
    chk("if_rdata_held", ifetch_rdata_o === mdata(32'h4000), ifetch_rdata_o,
        mdata(32'h4000));

    // Reset in the middle of a write
    data_op(2'd1, 32'h6000, 32'h1111_2222);
    cycle();
    cycle();
    #2;
    rst_ni = 1'b0;
    lat = 20;
    @(negedge clk_i);
    bits = {ctrl_req_o, ifetch_gnt_o, data_gnt_o, ifetch_rvalid_o, data_rvalid_o,
            init_done_o, busy_o};
    chk("mid_rst_bits", bits === 7'b0, bits, 7'b0);
    chk("mid_rst_rdata", {ifetch_rdata_o, data_rdata_o} === 64'h0,
        {ifetch_rdata_o, data_rdata_o}, 64'h0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    boot_reqs = 0;
    done_cyc = 0;
    rv0 = rv_cnt;
    for (int i = 0; i < 80 && done_cyc == 0; i++) begin
      cycle();
      if (i == 5) lat = 3;
    end
    chk("reboot_req_count", boot_reqs === 1, boot_reqs, 1);
    chk("reboot_op_qe", boot_op === 2'd3, boot_op, 2'd3);
    chk("reboot_no_rvalid", rv_cnt === rv0, rv_cnt, rv0);

`ifdef XIP_ARB_RDBUF_EN
    // Read buffer hit and invalidation
    ifetch_req_i = 1'b1;
    ifetch_addr_i = 32'h1004;
    cycle();
    chk("rb_first_ctrl", last_creq === 1'b1, last_creq, 1'b1);
    drain(20);
    ifetch_req_i = 1'b1;
    ifetch_addr_i = 32'h1006;
    cycle();
    chk("rb_hit_no_ctrl", last_creq === 1'b0, last_creq, 1'b0);
    drain(20);
    chk("rb_hit_latency", last_lat === 1, last_lat, 1);
    data_op(2'd1, 32'h1004, 32'h0);
    cycle();
    drain(20);
    data_op(2'd0, 32'h1004, 32'h0);
    cycle();
    chk("rb_inval_ctrl", last_creq === 1'b1, last_creq, 1'b1);
    drain(20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xip_flash_arbiter.md
XIP_FLASH_ARBITER -- requirements
Module: xip_flash_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while an ifetch request is pending.
REQ-002 SHALL have parameter BOOT_QE, default 1: when set, issue one OP_QUAD_ENABLE after reset before any grant.
REQ-003 SHALL have clk_i  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ifetch_req_i in 1, ifetch_addr_i in 32, ifetch_gnt_o out 1, ifetch_rvalid_o out 1, ifetch_rdata_o out 32: read-only fetch port.
REQ-006 SHALL have data_req_i in 1, data_op_i in 2, data_addr_i in 32, data_wdata_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32: data port carrying READ/WRITE/SECTOR_ERASE/QUAD_ENABLE.
REQ-007 SHALL have ctrl_req_o out 1, ctrl_op_o out 2, ctrl_addr_o out 32, ctrl_wdata_o out 32, ctrl_valid_i in 1, ctrl_rdata_i in 32: flash controller port.
REQ-008 SHALL have init_done_o out 1 (boot sequence complete) and busy_o out 1 (state is not S_IDLE).

Function
REQ-009 SHALL implement states S_BOOT, S_BOOT_WAIT, S_IDLE, S_WAIT.
REQ-010 S_BOOT SHALL pulse ctrl_req_o for one cycle with op QUAD_ENABLE and go to S_BOOT_WAIT; with BOOT_QE=0, S_BOOT SHALL go directly to S_IDLE without a request.
REQ-011 S_BOOT_WAIT SHALL go to S_IDLE on ctrl_valid_i; init_done_o SHALL set on entry to S_IDLE and stay set until reset.
REQ-012 In S_IDLE with any request, the arbiter SHALL assert exactly one gnt_o combinationally in that cycle, pulse ctrl_req_o for one cycle with the winner's op/addr/wdata (ifetch op = READ), and go to S_WAIT.
REQ-013 ctrl_req_o SHALL never be asserted outside S_BOOT and the grant cycle of S_IDLE; gnt_o SHALL be 0 outside S_IDLE.
REQ-014 ctrl_addr_o SHALL be the requester address with bits [1:0] forced to 0.
REQ-015 Priority: data port wins, except when the starvation counter equals STARVE_LIMIT and ifetch_req_i is high, in which case ifetch wins.
REQ-016 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each data grant while ifetch_req_i is high, and SHALL clear on an ifetch grant or on any cycle with ifetch_req_i low.
REQ-017 In S_WAIT, on ctrl_valid_i the arbiter SHALL register ctrl_rdata_i, pulse the owner's rvalid_o for one cycle in the next cycle, and return to S_IDLE. Grant-to-rvalid latency = controller latency + 1.
REQ-018 Write, erase and quad-enable SHALL also produce an rvalid_o pulse as completion; rdata is don't-care.
REQ-019 rdata_o SHALL hold its last value between pulses; the non-owner's rvalid_o SHALL stay 0.
REQ-020 Requesters SHALL hold req/addr/op/wdata stable until gnt_o; a request dropped before grant is discarded.
REQ-021 Requests arriving in S_BOOT, S_BOOT_WAIT or S_WAIT SHALL wait and are not lost while held.

Reset
REQ-022 On rst_ni low, state SHALL be S_BOOT, the starvation counter 0, and every output 0, including init_done_o and rdata; an in-flight transfer is abandoned without rvalid and boot reruns.

Configuration
REQ-023 With XIP_ARB_RDBUF_EN defined: a one-entry read buffer holds {addr[23:2], data, valid} from the last completed READ on either port.
REQ-024 With XIP_ARB_RDBUF_EN, a READ in S_IDLE whose addr[23:2] matches a valid entry SHALL be granted without ctrl_req_o, with rvalid_o one cycle later carrying the buffered data. The state SHALL remain S_IDLE, and that cycle SHALL count for starvation.
REQ-025 With XIP_ARB_RDBUF_EN, any WRITE, SECTOR_ERASE or QUAD_ENABLE grant SHALL clear the valid bit; reset SHALL also clear it.
REQ-026 Without XIP_ARB_RDBUF_EN, every READ SHALL access the controller and no buffer storage exists.

Structure
REQ-027 Package xip_pkg SHALL hold the op codes (READ=0, WRITE=1, SECTOR_ERASE=2, QUAD_ENABLE=3), shared with the flash controller, and the arbiter state enum.
REQ-028 The read buffer SHALL be sub-module xip_rd_buf, instantiated only under XIP_ARB_RDBUF_EN.

Verification
REQ-029 Reset with BOOT_QE=1 and a model valid after 20 cycles -> one ctrl_req_o with op=3, init_done_o=1 after valid, no grants before.
REQ-030 Both ports request READ at 0x100 and 0x200 in the same cycle -> data_gnt_o first with ctrl_addr_o=0x200; ifetch granted after data rvalid.
REQ-031 Data port issues continuous requests, ifetch pending, STARVE_LIMIT=4 -> ifetch granted on the 5th arbitration.
REQ-032 With RDBUF: ifetch READ 0x1004 then READ 0x1006 -> second request has no ctrl_req_o and rvalid returns the same data 1 cycle after grant; data WRITE 0x1004 then READ 0x1004 -> controller accessed.
REQ-033 rst_ni asserted during S_WAIT of a WRITE -> all outputs 0, no rvalid, boot QE reissued.
REQ-034 Data ifetch_addr_i=0x2003 -> ctrl_addr_o=0x2000.
